// File: rtl/saxi_stall_fifo.sv
// AXI4-Stream stage with a periodic input ready window
// feeding a first-word-fall-through FIFO.
module saxi_stall_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int IN_PERIOD  = 6
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     TVALID_IN,
  output logic                     TREADY_IN,
  input  logic [DATA_WIDTH-1:0]    TDATA_IN,
  input  logic                     TLAST_IN,
  output logic                     TVALID_OUT,
  input  logic                     TREADY_OUT,
  output logic [DATA_WIDTH-1:0]    TDATA_OUT,
  output logic                     TLAST_OUT,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(IN_PERIOD) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(IN_PERIOD - 1);

  logic [CW-1:0]       cnt;
  logic                run_ready;
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;

  // free-running window generator, blind to traffic
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt       <= '0;
      run_ready <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt       <= '0;
      run_ready <= 1'b1;
    end else begin
      cnt       <= cnt + CW'(1);
      run_ready <= 1'b0;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);

  assign TREADY_IN  = run_ready && !full;
  assign TVALID_OUT = !empty;
  assign push       = TVALID_IN && TREADY_IN;
  assign pop        = TVALID_OUT && TREADY_OUT;
  assign COUNT      = wr_ptr - rd_ptr;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // storage is deliberately left unreset
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {TLAST_IN, TDATA_IN};
  end

  assign {TLAST_OUT, TDATA_OUT} = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_saxi_stall_fifo.sv
// Bench for saxi_stall_fifo: two instances (period 6 and 1)
// checked each cycle against a queue-based model.
module tb_saxi_stall_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  typedef logic [DW:0] beat_t;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b1;
  logic          vin [2];
  logic          rdy_in [2];
  logic [DW-1:0] din [2];
  logic          lin [2];
  logic          vout [2];
  logic          rout [2];
  logic [DW-1:0] dout [2];
  logic          lout [2];
  logic [CW-1:0] cnt [2];

  int checks = 0;
  int errors = 0;
  int per [2] = '{6, 1};
  beat_t mq [2][$];
  int ecnt [2];
  int seq [2];
  bit rnd = 1'b0;

  always #5 ACLK = ~ACLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    saxi_stall_fifo #(
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH),
      .IN_PERIOD(g == 0 ? 6 : 1)
    ) u_dut (
      .ACLK(ACLK),
      .ARESETn(ARESETn),
      .TVALID_IN(vin[g]),
      .TREADY_IN(rdy_in[g]),
      .TDATA_IN(din[g]),
      .TLAST_IN(lin[g]),
      .TVALID_OUT(vout[g]),
      .TREADY_OUT(rout[g]),
      .TDATA_OUT(dout[g]),
      .TLAST_OUT(lout[g]),
      .COUNT(cnt[g])
    );
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ready window: cycles after edges P, 2P, ... since reset release
  function automatic logic exp_rdy(int g);
    return ecnt[g] > 0 && (ecnt[g] % per[g]) == 0 &&
           mq[g].size() < DEPTH;
  endfunction

  task automatic set_in(int g, logic v, logic r);
    vin[g]  = v;
    rout[g] = r;
    din[g]  = rnd ? DW'($urandom) : DW'(seq[g]);
    lin[g]  = rnd ? 1'($urandom_range(0, 1))
                  : ((seq[g] % 3) == 2);
  endtask

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      mq[g].delete();
      ecnt[g] = 0;
    end
  endtask

  task automatic cyc();
    logic push [2];
    logic pop [2];
    @(negedge ACLK);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("tready_in%0d", g), 64'(rdy_in[g]), 64'(exp_rdy(g)));
      chk($sformatf("tvalid_out%0d", g), 64'(vout[g]),
          64'(mq[g].size() != 0));
      chk($sformatf("count%0d", g), 64'(cnt[g]), 64'(mq[g].size()));
      if (mq[g].size() != 0)
        chk($sformatf("head%0d", g), 64'({lout[g], dout[g]}),
            64'(mq[g][0]));
      push[g] = vin[g] && exp_rdy(g);
      pop[g]  = (mq[g].size() != 0) && rout[g];
    end
    @(posedge ACLK);
    for (int g = 0; g < 2; g++) begin
      if (pop[g]) void'(mq[g].pop_front());
      if (push[g]) begin
        mq[g].push_back({lin[g], din[g]});
        seq[g]++;
      end
      ecnt[g]++;
    end
    #1;
  endtask

  initial begin
    int base;
    int n;
    for (int g = 0; g < 2; g++) begin
      seq[g] = 0;
      set_in(g, 1'b0, 1'b0);
    end
    model_reset();
    #1 ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_rdy%0d", g), 64'(rdy_in[g]), 64'(0));
      chk($sformatf("rst_vld%0d", g), 64'(vout[g]), 64'(0));
      chk($sformatf("rst_cnt%0d", g), 64'(cnt[g]), 64'(0));
    end
    ARESETn = 1'b1;

    // throttle: period-6 instance with source and sink always ready
    for (int c = 0; c < 20; c++) begin
      set_in(0, 1'b1, 1'b1);
      set_in(1, 1'b0, 1'b1);
      cyc();
    end
    chk("thr_accepted", 64'(seq[0]), 64'(3));

    // fill to full on the period-1 instance
    base = seq[1];
    for (int c = 0; c < 12; c++) begin
      set_in(0, 1'b0, 1'b1);
      set_in(1, (seq[1] - base) < 10, 1'b0);
      cyc();
    end
    chk("full_acc", 64'(seq[1] - base), 64'(8));
    chk("full_cnt", 64'(cnt[1]), 64'(8));
    chk("full_rdy", 64'(rdy_in[1]), 64'(0));
    n = 0;
    while (((seq[1] - base) < 10 || mq[1].size() != 0) && n < 40) begin
      set_in(0, 1'b0, 1'b1);
      set_in(1, (seq[1] - base) < 10, 1'b1);
      cyc();
      n++;
    end
    chk("drain_acc", 64'(seq[1] - base), 64'(10));
    chk("drain_empty", 64'(vout[1]), 64'(0));

    // steady push+pop at occupancy 4 across the pointer wrap
    n = 0;
    while (mq[1].size() < 4 && n < 20) begin
      set_in(0, 1'b0, 1'b1);
      set_in(1, 1'b1, 1'b0);
      cyc();
      n++;
    end
    for (int c = 0; c < 24; c++) begin
      set_in(0, 1'b0, 1'b1);
      set_in(1, 1'b1, 1'b1);
      cyc();
    end
    chk("pp_cnt", 64'(cnt[1]), 64'(4));

    // random traffic with random back-pressure on both instances
    rnd = 1'b1;
    base = seq[1];
    n = 0;
    while ((seq[1] - base) < 1000 && n < 8000) begin
      for (int g = 0; g < 2; g++)
        set_in(g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc();
      n++;
    end
    chk("rand_beats", 64'((seq[1] - base) >= 1000), 64'(1));
    rnd = 1'b0;

    // asynchronous reset with five beats buffered
    for (int c = 0; c < 20; c++) begin
      set_in(0, 1'b0, 1'b1);
      set_in(1, 1'b0, 1'b1);
      cyc();
    end
    n = 0;
    while (mq[1].size() < 5 && n < 20) begin
      set_in(0, 1'b0, 1'b0);
      set_in(1, 1'b1, 1'b0);
      cyc();
      n++;
    end
    chk("pre_rst_cnt", 64'(cnt[1]), 64'(5));
    set_in(1, 1'b0, 1'b0);
    #2 ARESETn = 1'b0;
    #1;
    chk("arst_vld", 64'(vout[1]), 64'(0));
    chk("arst_rdy", 64'(rdy_in[1]), 64'(0));
    chk("arst_cnt", 64'(cnt[1]), 64'(0));
    model_reset();
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      set_in(0, 1'b1, 1'b1);
      set_in(1, 1'b1, 1'($urandom_range(0, 1)));
      cyc();
    end
    for (int c = 0; c < 20; c++) begin
      set_in(0, 1'b0, 1'b1);
      set_in(1, 1'b0, 1'b1);
      cyc();
    end
    chk("end_empty0", 64'(vout[0]), 64'(0));
    chk("end_empty1", 64'(vout[1]), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/saxi_stall_fifo.md
# saxi_stall_fifo

Parametrised AXI4-Stream stage that throttles its input side with a programmable periodic ready pattern and buffers accepted beats in a first-word-fall-through FIFO. It drives a fully compliant output handshake that never drops data. It sits between a stream source and sink in the passthru test designs, and exercises back-pressure on both sides of the block under test. It succeeds the fixed 32-bit, single-register, period-6 passthrough, adding width/depth/period parameters, TLAST carriage, occupancy reporting and correct output back-pressure.

## Interface
- DATA_WIDTH, 32: TDATA width in bits, at least 1.
- DEPTH, 8: FIFO entries; a power of two, at least 2.
- IN_PERIOD, 6: input ready window recurs every IN_PERIOD cycles; 1 means ready every cycle; at least 1.
- ACLK  input  1  clock; all state changes on the rising edge.
- ARESETn  input  1  reset, asynchronous assert, active-low.
- TVALID_IN  input  1  upstream beat valid.
- TREADY_IN  output  1  stage accepts a beat this cycle.
- TDATA_IN  input  DATA_WIDTH  upstream data.
- TLAST_IN  input  1  upstream end-of-packet.
- TVALID_OUT  output  1  head-of-FIFO beat valid.
- TREADY_OUT  input  1  downstream accepts.
- TDATA_OUT  output  DATA_WIDTH  head data.
- TLAST_OUT  output  1  head end-of-packet.
- COUNT  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

## Operation
- Throttle: register cnt, width clog2(IN_PERIOD)+1, plus register run_ready.
  - Every edge: if cnt == IN_PERIOD-1, set cnt <= 0 and run_ready <= 1.
  - Otherwise set cnt <= cnt+1 and run_ready <= 0.
  - The counter free-runs and is independent of traffic.
- TREADY_IN = run_ready && !full.
- Push: when TVALID_IN && TREADY_IN, write {TLAST_IN, TDATA_IN} at wr_ptr and increment wr_ptr.
- Pop: when TVALID_OUT && TREADY_OUT, increment rd_ptr.
- Pointers are clog2(DEPTH)+1 bits and wrap naturally.
- empty when the pointers are equal. full when the low bits are equal and the MSBs differ.
- COUNT = wr_ptr - rd_ptr, taken modulo 2^(clog2(DEPTH)+1).
- TVALID_OUT = !empty. TDATA_OUT and TLAST_OUT are read combinationally from mem[rd_ptr]. They are undefined while TVALID_OUT=0.
- Simultaneous push and pop in the same cycle: COUNT is unchanged, and both pointers advance.
- Full with a pop in the same cycle: TREADY_IN stays 0 that cycle, so there is no push-through on full. Space is visible one cycle later.
- Empty with a push: no bypass. The beat appears on the output the next cycle.
- AXI rules:
  - Once TVALID_OUT=1, it and TDATA_OUT/TLAST_OUT hold until accepted.
  - TREADY_IN never depends combinationally on TVALID_IN.
- No beat is ever lost, duplicated or reordered. TLAST travels with its data word.

## Timing
- Reset (ARESETn=0, asynchronous): cnt=0, run_ready=0, wr_ptr=rd_ptr=0. Consequently TREADY_IN=0, TVALID_OUT=0, COUNT=0. FIFO memory is not reset.
- After reset release, the first ready window appears in the cycle following rising edge IN_PERIOD. It then repeats every IN_PERIOD cycles. For IN_PERIOD=1, TREADY_IN=1 (if not full) from the cycle after the first edge onward.
- Latency: a beat accepted at edge k is presented on the output with TVALID_OUT=1 in the cycle following edge k, if the FIFO was empty.
- Throughput: the input side sustains at most 1/IN_PERIOD beats per cycle. The output side sustains 1 beat per cycle while not empty.
- Reset asserted mid-packet flushes all contents immediately. Outputs take their reset values asynchronously.

## Test plan
- Reset and throttle: IN_PERIOD=6, TVALID_IN held 1, TREADY_OUT=1, data 0,1,2...
  - TREADY_IN is high only in the cycles after edges 6, 12, 18.
  - TDATA_OUT shows 0, 1, 2, each valid for exactly one cycle, one cycle after its acceptance.
- Fill to full: DEPTH=8, IN_PERIOD=1, TREADY_OUT=0, 10 beats offered.
  - Exactly 8 accepted; COUNT reaches 8; TREADY_IN drops to 0.
  - Release TREADY_OUT: output shows 8 beats in order, then beats 9 and 10 are accepted.
- Output back-pressure stability: TREADY_OUT toggled pseudo-randomly.
  - TDATA_OUT and TLAST_OUT never change while TVALID_OUT=1 and TREADY_OUT=0.
  - Scoreboard matches 1000 random beats.
- Simultaneous push/pop at COUNT=4: COUNT stays 4, and data order is preserved across the pointer wrap at the 16th beat.
- TLAST carriage: 3-beat packets with TLAST on every third beat. TLAST_OUT is asserted with exactly the same data words.
- Asynchronous reset mid-stream: ARESETn pulled low between edges with COUNT=5. TVALID_OUT, TREADY_IN and COUNT go to 0 before the next edge, and the stream restarts cleanly afterwards.
